// File: rtl/mcpu_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives datapath
// selects and enables, stalls on mem_ready, and counts retired instructions.
module mcpu_control_fsm #(
    parameter bit MEM_WAIT_EN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       dbg_state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_R_WB     = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_LW_WB    = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;
    logic             mem_done;

    // Handshake: a request (mem_read/mem_write) is held with a stable address until the
    // cycle mem_ready=1, which completes it; with MEM_WAIT_EN=0 every access completes at once.
    assign mem_done = MEM_WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = S_FETCH;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        illegal_op    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_done;
                pc_write  = mem_done;
                state_d   = mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                case (opcode)
                    OP_R:         state_d = S_EXEC_R;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    default:      illegal_op = 1'b1;
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
                state_d   = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
                retire    = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_done ? S_LW_WB : S_MEM_RD;
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
                retire     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_done;
                state_d   = mem_done ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
                retire        = 1'b1;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                retire    = 1'b1;
            end
            S_JAL: begin
                // PC was already advanced in FETCH, so PC is the link value
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
                pc_write   = 1'b1;
                pc_source  = 2'd2;
                retire     = 1'b1;
            end
            default: ;
        endcase
        // Reset drops any request in the same cycle, not only after the edge
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            i_or_d        = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            reg_dst       = 2'd0;
            mem_to_reg    = 2'd0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'd0;
            alu_op        = 2'd0;
            pc_source     = 2'd0;
            illegal_op    = 1'b0;
        end
        cnt_d = retire ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    end

    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Bench for mcpu_control_fsm: per-cycle expected control words go through a queue and
// are compared at the falling edge; retired counts are checked against a counter model.
module tb_mcpu_control_fsm;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_R_WB = 4'd3,
                           S_MEM_ADDR = 4'd4, S_MEM_RD = 4'd5, S_LW_WB = 4'd6, S_MEM_WR = 4'd7,
                           S_BRANCH = 4'd8, S_ADDI_EX = 4'd9, S_ADDI_WB = 4'd10, S_JUMP = 4'd11,
                           S_JAL = 4'd12;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                           OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rdy_a, rst_b, rdy_b;
    logic [5:0]  op_a, op_b;
    logic        pcw_a, pcwc_a, iod_a, mr_a, mw_a, irw_a, rw_a, asa_a, ill_a;
    logic [1:0]  rd_a, m2r_a, asb_a, aop_a, psrc_a;
    logic [31:0] cnt_a;
    logic [3:0]  st_a;
    logic        pcw_b, pcwc_b, iod_b, mr_b, mw_b, irw_b, rw_b, asa_b, ill_b;
    logic [1:0]  rd_b, m2r_b, asb_b, aop_b, psrc_b;
    logic [3:0]  cnt_b;
    logic [3:0]  st_b;

    mcpu_control_fsm #(.MEM_WAIT_EN(1'b1), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst_a), .opcode(op_a), .mem_ready(rdy_a),
        .pc_write(pcw_a), .pc_write_cond(pcwc_a), .i_or_d(iod_a), .mem_read(mr_a),
        .mem_write(mw_a), .ir_write(irw_a), .reg_write(rw_a), .reg_dst(rd_a),
        .mem_to_reg(m2r_a), .alu_src_a(asa_a), .alu_src_b(asb_a), .alu_op(aop_a),
        .pc_source(psrc_a), .illegal_op(ill_a), .instr_count(cnt_a), .dbg_state(st_a)
    );

    mcpu_control_fsm #(.MEM_WAIT_EN(1'b0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .opcode(op_b), .mem_ready(rdy_b),
        .pc_write(pcw_b), .pc_write_cond(pcwc_b), .i_or_d(iod_b), .mem_read(mr_b),
        .mem_write(mw_b), .ir_write(irw_b), .reg_write(rw_b), .reg_dst(rd_b),
        .mem_to_reg(m2r_b), .alu_src_a(asa_b), .alu_src_b(asb_b), .alu_op(aop_b),
        .pc_source(psrc_b), .illegal_op(ill_b), .instr_count(cnt_b), .dbg_state(st_b)
    );

    logic [22:0] obs_a, obs_b;
    assign obs_a = {st_a, pcw_a, pcwc_a, iod_a, mr_a, mw_a, irw_a, rw_a, rd_a, m2r_a,
                    asa_a, asb_a, aop_a, psrc_a, ill_a};
    assign obs_b = {st_b, pcw_b, pcwc_b, iod_b, mr_b, mw_b, irw_b, rw_b, rd_b, m2r_b,
                    asa_b, asb_b, aop_b, psrc_b, ill_b};

    logic [22:0] exp_q[$];
    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] cnt_a_m;
    logic [3:0]  cnt_b_m;
    logic [5:0]  op_tbl[7];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word from the state table; all outputs 0 while reset is high
    function automatic logic [22:0] exp_word(input logic [3:0] st, input logic [5:0] op,
                                             input logic rdy, input logic r, input logic wait_en);
        logic pw, pwc, iod, mr, mw, irw, rw, asa, ill, done;
        logic [1:0] rd, m2r, asb, aop, psrc;
        {pw, pwc, iod, mr, mw, irw, rw, asa, ill} = '0;
        {rd, m2r, asb, aop, psrc} = '0;
        done = wait_en ? rdy : 1'b1;
        if (!r) begin
            case (st)
                S_FETCH:    begin mr = 1; asb = 2'd1; irw = done; pw = done; end
                S_DECODE:   begin asb = 2'd3;
                                  ill = !(op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL}); end
                S_EXEC_R:   begin asa = 1; aop = 2'd2; end
                S_R_WB:     begin rw = 1; rd = 2'd1; end
                S_MEM_ADDR: begin asa = 1; asb = 2'd2; end
                S_MEM_RD:   begin mr = 1; iod = 1; end
                S_LW_WB:    begin rw = 1; m2r = 2'd1; end
                S_MEM_WR:   begin mw = 1; iod = 1; end
                S_BRANCH:   begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
                S_ADDI_EX:  begin asa = 1; asb = 2'd2; end
                S_ADDI_WB:  begin rw = 1; end
                S_JUMP:     begin pw = 1; psrc = 2'd2; end
                S_JAL:      begin rw = 1; rd = 2'd2; m2r = 2'd2; pw = 1; psrc = 2'd2; end
                default: ;
            endcase
        end
        return {st, pw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs, queue the expected word, compare at the falling edge
    task automatic step(input int which, input logic [3:0] st, input logic [5:0] op,
                        input logic rdy, input logic r, input string tag);
        logic [22:0] got, exp;
        if (which == 0) begin rst_a = r; op_a = op; rdy_a = rdy; end
        else            begin rst_b = r; op_b = op; rdy_b = rdy; end
        exp_q.push_back(exp_word(st, op, rdy, r, which == 0));
        @(negedge clk);
        got = (which == 0) ? obs_a : obs_b;
        exp = exp_q.pop_front();
        check(tag, {9'd0, got}, {9'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input int which, input string tag);
        if (which == 0) check(tag, cnt_a, cnt_a_m);
        else            check(tag, {28'd0, cnt_b}, {28'd0, cnt_b_m});
    endtask

    // Full instruction; fstall/mstall are ready-low cycles in FETCH and the data access
    task automatic do_instr(input int which, input logic [5:0] op, input int fstall,
                            input int mstall, input logic b_rdy);
        logic rd;
        rd = (which == 0) ? 1'b1 : b_rdy;
        repeat (fstall) step(which, S_FETCH, op, 1'b0, 1'b0, "fetch_stall");
        step(which, S_FETCH, op, rd, 1'b0, "fetch");
        step(which, S_DECODE, op, rnd_bit(), 1'b0, "decode");
        case (op)
            OP_R: begin
                step(which, S_EXEC_R, op, rnd_bit(), 1'b0, "exec_r");
                step(which, S_R_WB, op, rnd_bit(), 1'b0, "r_wb");
            end
            OP_LW: begin
                step(which, S_MEM_ADDR, op, rnd_bit(), 1'b0, "mem_addr");
                repeat (mstall) step(which, S_MEM_RD, op, 1'b0, 1'b0, "mem_rd_stall");
                step(which, S_MEM_RD, op, rd, 1'b0, "mem_rd");
                step(which, S_LW_WB, op, rnd_bit(), 1'b0, "lw_wb");
            end
            OP_SW: begin
                step(which, S_MEM_ADDR, op, rnd_bit(), 1'b0, "mem_addr");
                repeat (mstall) step(which, S_MEM_WR, op, 1'b0, 1'b0, "mem_wr_stall");
                step(which, S_MEM_WR, op, rd, 1'b0, "mem_wr");
            end
            OP_BEQ:  step(which, S_BRANCH, op, rnd_bit(), 1'b0, "branch");
            OP_ADDI: begin
                step(which, S_ADDI_EX, op, rnd_bit(), 1'b0, "addi_ex");
                step(which, S_ADDI_WB, op, rnd_bit(), 1'b0, "addi_wb");
            end
            OP_J:    step(which, S_JUMP, op, rnd_bit(), 1'b0, "jump");
            OP_JAL:  step(which, S_JAL, op, rnd_bit(), 1'b0, "jal");
            default: ;
        endcase
        if (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL}) begin
            if (which == 0) cnt_a_m = cnt_a_m + 32'd1;
            else            cnt_b_m = cnt_b_m + 4'd1;
        end
        check_count(which, "instr_count");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        op_tbl = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J, OP_JAL};
        rst_a = 1'b1; rst_b = 1'b1; op_a = OP_R; op_b = OP_R; rdy_a = 1'b1; rdy_b = 1'b1;
        cnt_a_m = 32'd0;
        cnt_b_m = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        step(0, S_FETCH, OP_R, 1'b1, 1'b1, "reset_outputs");
        check_count(0, "reset_count");

        do_instr(0, OP_R, 0, 0, 1'b1);
        do_instr(0, OP_LW, 0, 3, 1'b1);
        do_instr(0, OP_BEQ, 0, 0, 1'b1);
        do_instr(0, OP_J, 0, 0, 1'b1);
        do_instr(0, OP_JAL, 0, 0, 1'b1);
        do_instr(0, OP_BAD, 0, 0, 1'b1);
        do_instr(0, OP_R, 2, 0, 1'b1);
        do_instr(0, OP_SW, 0, 1, 1'b1);
        do_instr(0, OP_ADDI, 1, 0, 1'b1);
        for (int i = 0; i < 10; i++)
            do_instr(0, op_tbl[$urandom_range(0, 6)], $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);

        // Reset while a store is stalled: request must drop in the reset cycle itself
        step(0, S_FETCH, OP_SW, 1'b1, 1'b0, "fetch");
        step(0, S_DECODE, OP_SW, 1'b1, 1'b0, "decode");
        step(0, S_MEM_ADDR, OP_SW, 1'b1, 1'b0, "mem_addr");
        step(0, S_MEM_WR, OP_SW, 1'b0, 1'b0, "mem_wr_stall");
        step(0, S_MEM_WR, OP_SW, 1'b0, 1'b0, "mem_wr_stall");
        step(0, S_MEM_WR, OP_SW, 1'b0, 1'b1, "rst_in_mem_wr");
        cnt_a_m = 32'd0;
        check_count(0, "count_after_rst");
        do_instr(0, OP_R, 0, 0, 1'b1);

        // No-wait instance, 4-bit counter: ready ignored, wraps after 16 retirements
        rst_a = 1'b1;
        rst_b = 1'b0;
        do_instr(1, OP_SW, 0, 0, 1'b0);
        for (int i = 0; i < 15; i++)
            do_instr(1, op_tbl[$urandom_range(0, 6)], 0, 0, rnd_bit());
        check("count_wrap", {28'd0, cnt_b}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
